// File: rtl/hs_dac_tx_if.sv
// hs_dac_tx_if: sample-pair handshake between the fabric and hs_dac_tx.
//   din        16-bit packed pair, din[15:8] sent first
//   din_valid  din is valid this cycle (driven by master)
//   din_ready  slave accepts din this cycle (driven by slave)
interface hs_dac_tx_if;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/hs_dac_tx.sv
// hs_dac_tx: buffers 16-bit sample pairs in a FIFO and serialises them onto an
// 8-bit DAC bus, one byte per sys_clk, upper byte first. Handles enable/sleep,
// prefill before streaming and sticky underflow with automatic re-priming.
// Ports:
//   sys_clk, sys_rst  clock and synchronous active-high reset
//   enable            1 = stream, 0 = stop and sleep
//   s_in              din/din_valid/din_ready handshake (slave side)
//   underflow_clr     pulse clearing the underflow flag
//   dac_data          registered DAC sample
//   dac_sleep         registered DAC power-down
//   underflow         sticky underflow flag
//   running           high while streaming
//   fifo_level        FIFO occupancy in words
module hs_dac_tx #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PREFILL    = 4,
    parameter logic [7:0]  IDLE_CODE  = 8'h80,
    localparam int unsigned AW        = $clog2(FIFO_DEPTH),
    localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          enable,
    hs_dac_tx_if.slave    s_in,
    input  logic          underflow_clr,
    output logic [7:0]    dac_data,
    output logic          dac_sleep,
    output logic          underflow,
    output logic          running,
    output logic [LW-1:0] fifo_level
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PREFILL = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          phase_q, phase_d;
    logic [7:0]    held_q, held_d;
    logic [7:0]    dac_q, dac_d;
    logic          sleep_q, sleep_d;
    logic          underflow_q, underflow_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   mem_q [FIFO_DEPTH];

    logic          wr_en;
    logic          pop;
    logic          uf_set;
    logic [15:0]   rd_word;

    assign s_in.din_ready = (state_q != ST_IDLE) && (level_q != LW'(FIFO_DEPTH));
    assign wr_en          = s_in.din_valid && s_in.din_ready;
    assign rd_word        = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        held_d  = held_q;
        dac_d   = dac_q;
        pop     = 1'b0;
        uf_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dac_d   = IDLE_CODE;
                phase_d = 1'b0;
                if (enable) state_d = ST_PREFILL;
            end
            ST_PREFILL: begin
                dac_d   = IDLE_CODE;
                phase_d = 1'b0;
                if (!enable)                      state_d = ST_IDLE;
                else if (level_q >= LW'(PREFILL)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (phase_q) begin
                    // Lower byte always goes out, even if enable just fell.
                    dac_d   = held_q;
                    phase_d = 1'b0;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                    dac_d   = IDLE_CODE;
                end else if (level_q == '0) begin
                    state_d = ST_PREFILL;
                    dac_d   = IDLE_CODE;
                    uf_set  = 1'b1;
                end else begin
                    pop     = 1'b1;
                    dac_d   = rd_word[15:8];
                    held_d  = rd_word[7:0];
                    phase_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dac_d   = IDLE_CODE;
                phase_d = 1'b0;
            end
        endcase

        // FIFO is held flushed whenever the next state is IDLE.
        if (state_d == ST_IDLE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
            case ({wr_en, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end

        sleep_d     = (state_d == ST_IDLE);
        underflow_d = uf_set || (underflow_q && !underflow_clr);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            held_q      <= '0;
            dac_q       <= IDLE_CODE;
            sleep_q     <= 1'b1;
            underflow_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            held_q      <= held_d;
            dac_q       <= dac_d;
            sleep_q     <= sleep_d;
            underflow_q <= underflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= s_in.din;
    end

    assign dac_data   = dac_q;
    assign dac_sleep  = sleep_q;
    assign underflow  = underflow_q;
    assign running    = (state_q == ST_RUN);
    assign fifo_level = level_q;
endmodule
